// File: rtl/pipelined_control_if.sv
// Bundles the ID-stage inputs and the per-stage control and counter outputs of the pipeline control unit.
interface pipelined_control_if #(
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16
);
  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_W-1:0]    id_rs;
  logic [REG_W-1:0]    id_rt;
  logic [REG_W-1:0]    id_rd;
  logic                mem_zero;
  logic [3:0]          ex_ctrl;
  logic [REG_W-1:0]    ex_dst;
  logic [2:0]          mem_ctrl;
  logic [REG_W-1:0]    mem_dst;
  logic [1:0]          wb_ctrl;
  logic [REG_W-1:0]    wb_dst;
  logic                stall;
  logic                flush;
  logic                illegal_op;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, mem_zero,
    input  ex_ctrl, ex_dst, mem_ctrl, mem_dst, wb_ctrl, wb_dst,
           stall, flush, illegal_op, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, mem_zero,
    output ex_ctrl, ex_dst, mem_ctrl, mem_dst, wb_ctrl, wb_dst,
           stall, flush, illegal_op, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipelined_control.sv
// Pipeline control unit: ID decode, control/dst carried through ID/EX, EX/MEM and MEM/WB,
// load-use stall, MEM-stage branch flush and saturating stall/flush counters.
module pipelined_control #(
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_control_if.slave bus
);

  typedef struct packed {
    logic [1:0] wb;   // {regWrite, memToReg}
    logic [2:0] mem;  // {branch, memRead, memWrite}
    logic [3:0] ex;   // {regDst, aluOp1, aluOp0, aluSrc}
  } ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  ctrl_t            ex_c_q, ex_c_d;
  logic [REG_W-1:0] ex_dst_q, ex_dst_d;
  logic [1:0]       mem_wb_q, mem_wb_d;
  logic [2:0]       mem_c_q, mem_c_d;
  logic [REG_W-1:0] mem_dst_q, mem_dst_d;
  logic [1:0]       wb_c_q, wb_c_d;
  logic [REG_W-1:0] wb_dst_q, wb_dst_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  ctrl_t            dec;
  logic             dec_illegal;
  logic             hz, flush, stall;

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    case (bus.id_opcode)
      OP_R:    dec = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100};
      OP_LW:   dec = '{wb: 2'b11, mem: 3'b010, ex: 4'b0001};
      OP_SW:   dec = '{wb: 2'b00, mem: 3'b001, ex: 4'b0001};
      OP_BEQ:  dec = '{wb: 2'b00, mem: 3'b100, ex: 4'b0010};
      OP_ADDI: dec = '{wb: 2'b10, mem: 3'b000, ex: 4'b0001};
      default: dec_illegal = 1'b1;
    endcase
  end

  // Hazard detection and branch resolution; flush wins over the load-use stall.
  always_comb begin
    hz    = bus.id_valid & ex_c_q.mem[1] & (ex_dst_q != '0) &
            ((ex_dst_q == bus.id_rs) | (ex_dst_q == bus.id_rt));
    flush = mem_c_q[2] & bus.mem_zero;
    stall = hz & ~flush;
  end

  always_comb begin
    ex_c_d      = '0;
    ex_dst_d    = '0;
    mem_wb_d    = ex_c_q.wb;
    mem_c_d     = ex_c_q.mem;
    mem_dst_d   = ex_dst_q;
    wb_c_d      = mem_wb_q;
    wb_dst_d    = mem_dst_q;
    illegal_d   = 1'b0;
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    flush_cnt_d = sat_inc(flush_cnt_q, flush);
    if (flush) begin
      mem_wb_d  = '0;
      mem_c_d   = '0;
      mem_dst_d = '0;
    end else if (!stall && bus.id_valid) begin
      ex_c_d    = dec;
      ex_dst_d  = dec_illegal ? '0 : (dec.ex[3] ? bus.id_rd : bus.id_rt);
      illegal_d = dec_illegal;
    end
  end

  // ID/EX | EX/MEM | MEM/WB registers and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_c_q      <= '0;
      ex_dst_q    <= '0;
      mem_wb_q    <= '0;
      mem_c_q     <= '0;
      mem_dst_q   <= '0;
      wb_c_q      <= '0;
      wb_dst_q    <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_c_q      <= ex_c_d;
      ex_dst_q    <= ex_dst_d;
      mem_wb_q    <= mem_wb_d;
      mem_c_q     <= mem_c_d;
      mem_dst_q   <= mem_dst_d;
      wb_c_q      <= wb_c_d;
      wb_dst_q    <= wb_dst_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ex_ctrl    = ex_c_q.ex;
  assign bus.ex_dst     = ex_dst_q;
  assign bus.mem_ctrl   = mem_c_q;
  assign bus.mem_dst    = mem_dst_q;
  assign bus.wb_ctrl    = wb_c_q;
  assign bus.wb_dst     = wb_dst_q;
  assign bus.stall      = stall;
  assign bus.flush      = flush;
  assign bus.illegal_op = illegal_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipelined_control.sv
// Directed bench for pipelined_control; a CNT_W=2 copy runs in lockstep to exercise counter saturation.
module tb_pipelined_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       t_valid;
  logic [5:0] t_op;
  logic [4:0] t_rs, t_rt, t_rd;
  logic       t_zero;

  int n_vec = 0;
  int n_err = 0;

  pipelined_control_if #(.OPCODE_W(6), .REG_W(5), .CNT_W(16)) ifc16 ();
  pipelined_control_if #(.OPCODE_W(6), .REG_W(5), .CNT_W(2))  ifc2 ();

  assign ifc16.id_valid = t_valid;
  assign ifc16.id_opcode = t_op;
  assign ifc16.id_rs = t_rs;
  assign ifc16.id_rt = t_rt;
  assign ifc16.id_rd = t_rd;
  assign ifc16.mem_zero = t_zero;
  assign ifc2.id_valid = t_valid;
  assign ifc2.id_opcode = t_op;
  assign ifc2.id_rs = t_rs;
  assign ifc2.id_rt = t_rt;
  assign ifc2.id_rd = t_rd;
  assign ifc2.mem_zero = t_zero;

  pipelined_control #(.OPCODE_W(6), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc16.slave));
  pipelined_control #(.OPCODE_W(6), .REG_W(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(ifc2.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic z);
    t_valid = v; t_op = op; t_rs = rs; t_rt = rt; t_rd = rd; t_zero = z;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ex_ctrl"},  32'(ifc16.ex_ctrl), 32'd0);
    chk({tag, ".ex_dst"},   32'(ifc16.ex_dst), 32'd0);
    chk({tag, ".mem_ctrl"}, 32'(ifc16.mem_ctrl), 32'd0);
    chk({tag, ".mem_dst"},  32'(ifc16.mem_dst), 32'd0);
    chk({tag, ".wb_ctrl"},  32'(ifc16.wb_ctrl), 32'd0);
    chk({tag, ".wb_dst"},   32'(ifc16.wb_dst), 32'd0);
    chk({tag, ".stall"},    32'(ifc16.stall), 32'd0);
    chk({tag, ".flush"},    32'(ifc16.flush), 32'd0);
    chk({tag, ".illegal"},  32'(ifc16.illegal_op), 32'd0);
    chk({tag, ".stall_cnt"}, 32'(ifc16.stall_cnt), 32'd0);
    chk({tag, ".flush_cnt"}, 32'(ifc16.flush_cnt), 32'd0);
    chk({tag, ".stall_cnt2"}, 32'(ifc2.stall_cnt), 32'd0);
  endtask

  initial begin
    idle();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // R-format through all three stages
    drive(1'b1, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    chk("r.ex_ctrl", 32'(ifc16.ex_ctrl), 32'b1100);
    chk("r.ex_dst", 32'(ifc16.ex_dst), 32'd3);
    idle();
    tick();
    chk("r.mem_ctrl", 32'(ifc16.mem_ctrl), 32'b000);
    chk("r.mem_dst", 32'(ifc16.mem_dst), 32'd3);
    tick();
    chk("r.wb_ctrl", 32'(ifc16.wb_ctrl), 32'b10);
    chk("r.wb_dst", 32'(ifc16.wb_dst), 32'd3);

    // Load-use: LW r4 then R using r4
    drive(1'b1, 6'd1, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    chk("lw.ex_ctrl", 32'(ifc16.ex_ctrl), 32'b0001);
    chk("lw.ex_dst", 32'(ifc16.ex_dst), 32'd4);
    drive(1'b1, 6'd0, 5'd4, 5'd5, 5'd6, 1'b0);
    chk("lu.stall", 32'(ifc16.stall), 32'd1);
    tick();
    chk("lu.ex_bubble", 32'(ifc16.ex_ctrl), 32'b0000);
    chk("lu.mem_ctrl", 32'(ifc16.mem_ctrl), 32'b010);
    chk("lu.stall_cnt", 32'(ifc16.stall_cnt), 32'd1);
    chk("lu.stall_clr", 32'(ifc16.stall), 32'd0);
    tick();
    chk("lu.r_enters", 32'(ifc16.ex_ctrl), 32'b1100);
    chk("lu.r_dst", 32'(ifc16.ex_dst), 32'd6);
    chk("lu.stall_cnt_hold", 32'(ifc16.stall_cnt), 32'd1);

    // LW to r0 never stalls
    drive(1'b1, 6'd1, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'd0, 5'd0, 5'd0, 5'd7, 1'b0);
    chk("lu_r0.stall", 32'(ifc16.stall), 32'd0);
    tick();
    idle();
    chk("lu_r0.stall_cnt", 32'(ifc16.stall_cnt), 32'd1);
    tick(); tick(); tick();

    // BEQ taken: flush two younger instructions
    drive(1'b1, 6'd3, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    chk("beq.ex_ctrl", 32'(ifc16.ex_ctrl), 32'b0010);
    drive(1'b1, 6'd0, 5'd7, 5'd8, 5'd9, 1'b0);
    tick();
    chk("beq.mem_ctrl", 32'(ifc16.mem_ctrl), 32'b100);
    drive(1'b1, 6'd4, 5'd1, 5'd10, 5'd0, 1'b1);
    chk("beq.flush", 32'(ifc16.flush), 32'd1);
    chk("beq.stall", 32'(ifc16.stall), 32'd0);
    tick();
    idle();
    chk("beq.ex_bubble", 32'(ifc16.ex_ctrl), 32'b0000);
    chk("beq.ex_dst", 32'(ifc16.ex_dst), 32'd0);
    chk("beq.mem_bubble", 32'(ifc16.mem_ctrl), 32'b000);
    chk("beq.mem_dst", 32'(ifc16.mem_dst), 32'd0);
    chk("beq.wb_ctrl", 32'(ifc16.wb_ctrl), 32'b00);
    chk("beq.flush_cnt", 32'(ifc16.flush_cnt), 32'd1);
    chk("beq.flush_clr", 32'(ifc16.flush), 32'd0);

    // BEQ not taken
    drive(1'b1, 6'd3, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("bnt.mem_ctrl", 32'(ifc16.mem_ctrl), 32'b100);
    chk("bnt.flush", 32'(ifc16.flush), 32'd0);
    tick();
    chk("bnt.flush_cnt", 32'(ifc16.flush_cnt), 32'd1);

    // Flush and load-use hazard in the same cycle
    drive(1'b1, 6'd3, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'd1, 5'd1, 5'd11, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'd0, 5'd11, 5'd1, 5'd2, 1'b1);
    chk("fh.flush", 32'(ifc16.flush), 32'd1);
    chk("fh.stall", 32'(ifc16.stall), 32'd0);
    tick();
    idle();
    chk("fh.stall_cnt", 32'(ifc16.stall_cnt), 32'd1);
    chk("fh.flush_cnt", 32'(ifc16.flush_cnt), 32'd2);
    chk("fh.ex_bubble", 32'(ifc16.ex_ctrl), 32'b0000);
    chk("fh.mem_bubble", 32'(ifc16.mem_ctrl), 32'b000);
    chk("fh.wb_ctrl", 32'(ifc16.wb_ctrl), 32'b00);

    // ADDI and SW decode
    drive(1'b1, 6'd4, 5'd1, 5'd13, 5'd14, 1'b0);
    tick();
    chk("addi.ex_ctrl", 32'(ifc16.ex_ctrl), 32'b0001);
    chk("addi.ex_dst", 32'(ifc16.ex_dst), 32'd13);
    drive(1'b1, 6'd2, 5'd1, 5'd15, 5'd16, 1'b0);
    tick();
    idle();
    chk("sw.ex_ctrl", 32'(ifc16.ex_ctrl), 32'b0001);
    tick();
    chk("addi.wb_ctrl", 32'(ifc16.wb_ctrl), 32'b10);
    chk("addi.wb_dst", 32'(ifc16.wb_dst), 32'd13);
    chk("sw.mem_ctrl", 32'(ifc16.mem_ctrl), 32'b001);
    tick();

    // Undefined opcode
    drive(1'b1, 6'h3F, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    idle();
    chk("ill.pulse", 32'(ifc16.illegal_op), 32'd1);
    chk("ill.ex_ctrl", 32'(ifc16.ex_ctrl), 32'b0000);
    chk("ill.ex_dst", 32'(ifc16.ex_dst), 32'd0);
    chk("ill.stall", 32'(ifc16.stall), 32'd0);
    chk("ill.flush", 32'(ifc16.flush), 32'd0);
    tick();
    chk("ill.clear", 32'(ifc16.illegal_op), 32'd0);
    chk("ill.mem_ctrl", 32'(ifc16.mem_ctrl), 32'b000);
    chk("ill.mem_dst", 32'(ifc16.mem_dst), 32'd0);
    chk("sat.pre2", 32'(ifc2.stall_cnt), 32'd1);

    // Five load-use pairs: 16-bit counter reaches 6, 2-bit saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'd1, 5'd1, 5'd12, 5'd0, 1'b0);
      tick();
      drive(1'b1, 6'd0, 5'd12, 5'd2, 5'd3, 1'b0);
      tick();
      tick();
    end
    idle();
    chk("sat.cnt2", 32'(ifc2.stall_cnt), 32'd3);
    chk("sat.cnt16", 32'(ifc16.stall_cnt), 32'd6);
    chk("sat.flush2", 32'(ifc2.flush_cnt), 32'd2);
    tick();
    chk("sat.hold2", 32'(ifc2.stall_cnt), 32'd3);

    // Asynchronous reset mid-stream
    drive(1'b1, 6'd1, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'd0, 5'd4, 5'd5, 5'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    idle();
    chk("post_rst.ex_ctrl", 32'(ifc16.ex_ctrl), 32'b1100);
    tick(); tick();
    chk("post_rst.wb_dst", 32'(ifc16.wb_dst), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
- Next-generation control unit for the 5-stage pipelined datapath. Decodes the opcode in ID into the same three control bundles as the single-cycle unit: WB {regWrite, memToReg}, MEM {branch, memRead, memWrite} and EX {regDst, aluOp1, aluOp0, aluSrc}.
- Carries those bundles and the destination register through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts a bubble. Resolves branches in MEM and flushes younger instructions.
- Maintains saturating stall and flush counters for performance debug.

Parameters:
- OPCODE_W, 6, opcode width.
- REG_W, 5, register-address width.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  OPCODE_W  opcode in ID.
- id_rs  in  REG_W  source register 1 in ID.
- id_rt  in  REG_W  source register 2 / load-type destination in ID.
- id_rd  in  REG_W  R-format destination in ID.
- mem_zero  in  1  ALU zero flag held in the EX/MEM register.
- ex_ctrl  out  4  {regDst, aluOp1, aluOp0, aluSrc} from ID/EX.
- ex_dst  out  REG_W  destination register from ID/EX.
- mem_ctrl  out  3  {branch, memRead, memWrite} from EX/MEM.
- mem_dst  out  REG_W  destination register from EX/MEM.
- wb_ctrl  out  2  {regWrite, memToReg} from MEM/WB.
- wb_dst  out  REG_W  destination register from MEM/WB.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- flush  out  1  combinational; squash IF/ID this cycle.
- illegal_op  out  1  registered; pulses 1 cycle after an undefined opcode in ID.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous, active-low. While rst_n=0, every register and output is 0: all control bundles, dst fields, illegal_op and both counters. stall and flush evaluate to 0 because they are derived from the zeroed registers.
- Decode (combinational, values 0/1 only, never x):
  - 0 R-format: regWrite=1, memToReg=0, branch=0, memRead=0, memWrite=0, regDst=1, aluOp=10, aluSrc=0.
  - 1 LW: regWrite=1, memToReg=1, memRead=1, regDst=0, aluOp=00, aluSrc=1.
  - 2 SW: memWrite=1, aluOp=00, aluSrc=1; all else 0.
  - 3 BEQ: branch=1, aluOp=01; all else 0.
  - 4 ADDI (new): regWrite=1, regDst=0, aluOp=00, aluSrc=1; all else 0.
  - Any other value: all-zero bubble, and illegal_op=1 on the next cycle if the instruction was actually accepted.
- Destination: dst = regDst ? id_rd : id_rt. Bubbles carry dst=0.
- Load-use hazard: hz = id_valid & ex_memRead & (ex_dst!=0) & (ex_dst==id_rs | ex_dst==id_rt). Compare rt for every opcode; this is conservative and intended.
- Branch resolution: flush = mem_branch & mem_zero, where mem_branch = mem_ctrl[2].
- Precedence: flush overrides hz.
  - stall = hz & ~flush.
  - On flush: ID/EX and EX/MEM both load bubbles (squashes the two younger instructions in flight); MEM/WB loads EX/MEM normally, so the branch itself retires.
  - On stall without flush: ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
  - Otherwise: ID/EX loads decode if id_valid=1, else a bubble.
- Latency: an instruction decoded in cycle n appears on ex_* at n+1, mem_* at n+2, wb_* at n+3.
- illegal_op: asserted only when the undefined opcode is actually loaded into ID/EX, i.e. id_valid=1 and no stall and no flush.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush=1.
  - Both saturate at 2^CNT_W-1; no wrap.
- Reset mid-operation: the pipeline empties immediately. The first instruction after release follows the normal 3-cycle latency.

Test Plan:
- Reset, then R-format (rs=1, rt=2, rd=3) with id_valid=1 → ex_ctrl=1100, ex_dst=3 at n+1; mem_ctrl=000 at n+2; wb_ctrl=10, wb_dst=3 at n+3.
- LW (rt=4), then R-format with rs=4 → stall=1 for exactly 1 cycle, bubble in EX (ex_ctrl=0000), stall_cnt=1. Repeat with LW to r0 → stall stays 0.
- BEQ with mem_zero=1 at MEM → flush=1; ex_*/mem_* bubbles next cycle; wb_ctrl=00 for the BEQ; flush_cnt=1. With mem_zero=0 → no flush.
- Flush and load-use hazard in the same cycle → flush=1, stall=0, stall_cnt unchanged.
- Opcode 6'h3F, id_valid=1 → illegal_op=1 for one cycle, bubble down the pipe, no x on any output.
- CNT_W=2 with 5 consecutive load-use pairs → stall_cnt=3 held. Assert rst_n low mid-stream → all outputs 0 asynchronously, before the next clk edge.
